// File: rtl/track_access_arbiter.sv
// Shares the single-port track tile BRAM between the renderer (absolute priority)
// and the physics engine (valid/ready), returning each word to its issuer.
module track_access_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 4,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              render_active,
  input  logic [ADDR_W-1:0] render_addr,
  output logic              render_rsp_valid,
  output logic [DATA_W-1:0] render_rsp_data,
  input  logic              phys_req_valid,
  input  logic [ADDR_W-1:0] phys_req_addr,
  output logic              phys_req_ready,
  output logic              phys_rsp_valid,
  output logic [DATA_W-1:0] phys_rsp_data,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              starve_flag,
  input  logic              starve_clr
);

  localparam int PIPE_D = 1 + RD_LATENCY;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GRANT_IDLE   = 2'd0,
    GRANT_RENDER = 2'd1,
    GRANT_PHYS   = 2'd2
  } grant_t;

  grant_t              grant;
  logic [ADDR_W-1:0]   grant_addr;
  logic [PIPE_D-1:0]   tag_vld;
  logic [PIPE_D-1:0]   tag_own;
  logic [CNT_W-1:0]    wait_cnt;
  logic [CNT_W-1:0]    wait_cnt_next;
  logic                blocked;

  // Ready is a function of render_active and reset only, never of phys_req_valid.
  always_comb begin
    grant          = GRANT_IDLE;
    grant_addr     = bram_addr;
    phys_req_ready = 1'b0;
    if (!rst_in) begin
      if (render_active) begin
        grant      = GRANT_RENDER;
        grant_addr = render_addr;
      end else begin
        phys_req_ready = 1'b1;
        if (phys_req_valid) begin
          grant      = GRANT_PHYS;
          grant_addr = phys_req_addr;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bram_addr <= '0;
      bram_en   <= 1'b0;
    end else begin
      bram_addr <= grant_addr;
      bram_en   <= (grant != GRANT_IDLE);
    end
  end

  // Owner tag rides alongside the read: 0 = render, 1 = physics.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag_vld <= '0;
      tag_own <= '0;
    end else begin
      tag_vld <= {tag_vld[PIPE_D-2:0], grant != GRANT_IDLE};
      tag_own <= {tag_own[PIPE_D-2:0], grant == GRANT_PHYS};
    end
  end

  assign render_rsp_valid = tag_vld[PIPE_D-1] & ~tag_own[PIPE_D-1];
  assign phys_rsp_valid   = tag_vld[PIPE_D-1] &  tag_own[PIPE_D-1];
  assign render_rsp_data  = bram_dout;
  assign phys_rsp_data    = bram_dout;

  assign blocked = phys_req_valid & ~phys_req_ready;

  always_comb begin
    wait_cnt_next = '0;
    if (blocked) begin
      if (wait_cnt == CNT_MAX) wait_cnt_next = wait_cnt;
      else                     wait_cnt_next = wait_cnt + CNT_W'(1);
    end
  end

  // A clear in the same cycle as the limit being reached wins.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wait_cnt    <= '0;
      starve_flag <= 1'b0;
    end else if (starve_clr) begin
      wait_cnt    <= '0;
      starve_flag <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_next;
      if (wait_cnt_next == CNT_MAX) starve_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_track_access_arbiter.sv
// Directed bench for track_access_arbiter with a 2-cycle BRAM model and
// hand-computed per-cycle expectations.
module tb_track_access_arbiter;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       render_active = 1'b0;
  logic [7:0] render_addr = '0;
  logic       render_rsp_valid;
  logic [3:0] render_rsp_data;
  logic       phys_req_valid = 1'b0;
  logic [7:0] phys_req_addr = '0;
  logic       phys_req_ready;
  logic       phys_rsp_valid;
  logic [3:0] phys_rsp_data;
  logic [7:0] bram_addr;
  logic       bram_en;
  logic [3:0] bram_dout;
  logic       starve_flag;
  logic       starve_clr = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int step_no = 0;

  logic [3:0] mem [256];
  logic [3:0] rd1 = '0;
  logic [3:0] rd2 = '0;

  track_access_arbiter #(
    .ADDR_W(8), .DATA_W(4), .RD_LATENCY(2), .STARVE_LIMIT(8)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .render_active(render_active), .render_addr(render_addr),
    .render_rsp_valid(render_rsp_valid), .render_rsp_data(render_rsp_data),
    .phys_req_valid(phys_req_valid), .phys_req_addr(phys_req_addr),
    .phys_req_ready(phys_req_ready), .phys_rsp_valid(phys_rsp_valid),
    .phys_rsp_data(phys_rsp_data), .bram_addr(bram_addr), .bram_en(bram_en),
    .bram_dout(bram_dout), .starve_flag(starve_flag), .starve_clr(starve_clr)
  );

  always #5 clk_in = ~clk_in;

  // Two-cycle read BRAM: registered address in, data two edges later.
  always @(posedge clk_in) begin
    if (bram_en) rd1 <= mem[bram_addr];
    rd2 <= rd1;
  end
  assign bram_dout = rd2;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs mid-cycle, advance past the next edge.
  task automatic cyc(input logic ra, input logic [7:0] raddr,
                     input logic pv, input logic [7:0] paddr,
                     input logic e_rdy, input logic e_en,
                     input logic e_rv, input logic [3:0] e_rd,
                     input logic e_pv, input logic [3:0] e_pd,
                     input logic e_sf);
    render_active  = ra;
    render_addr    = raddr;
    phys_req_valid = pv;
    phys_req_addr  = paddr;
    #1;
    chk("phys_req_ready",   8'(phys_req_ready),   8'(e_rdy));
    chk("bram_en",          8'(bram_en),          8'(e_en));
    chk("render_rsp_valid", 8'(render_rsp_valid), 8'(e_rv));
    chk("phys_rsp_valid",   8'(phys_rsp_valid),   8'(e_pv));
    chk("starve_flag",      8'(starve_flag),      8'(e_sf));
    if (e_rv) chk("render_rsp_data", 8'(render_rsp_data), 8'(e_rd));
    if (e_pv) chk("phys_rsp_data",   8'(phys_rsp_data),   8'(e_pd));
    step_no++;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 4'h0;
    mem[8'h00] = 4'h1; mem[8'h01] = 4'h2; mem[8'h10] = 4'h3; mem[8'h11] = 4'h4;
    mem[8'h25] = 4'h5; mem[8'h26] = 4'h6; mem[8'h30] = 4'hB; mem[8'h60] = 4'h3;
    mem[8'h40] = 4'h7; mem[8'h41] = 4'h8; mem[8'h42] = 4'h9;
    mem[8'h50] = 4'hC; mem[8'h51] = 4'hD; mem[8'h52] = 4'hE;

    // Reset state; ready must stay low even with physics valid and render idle
    phys_req_valid = 1'b1;
    phys_req_addr  = 8'h25;
    #1 rst_in = 1'b1;
    #2;
    chk("rst_ready",  8'(phys_req_ready),   8'h0);
    chk("rst_en",     8'(bram_en),          8'h0);
    chk("rst_addr",   bram_addr,            8'h00);
    chk("rst_rv",     8'(render_rsp_valid), 8'h0);
    chk("rst_pv",     8'(phys_rsp_valid),   8'h0);
    chk("rst_sf",     8'(starve_flag),      8'h0);
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_in = 1'b0;
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h0, 0, 4'h0, 0);

    // Render only
    cyc(1, 8'h00, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 0);
    cyc(1, 8'h01, 0, 8'h00, 0, 1, 0, 4'h0, 0, 4'h0, 0);
    cyc(1, 8'h10, 0, 8'h00, 0, 1, 0, 4'h0, 0, 4'h0, 0);
    cyc(1, 8'h11, 0, 8'h00, 0, 1, 1, 4'h1, 0, 4'h0, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 1, 1, 4'h2, 0, 4'h0, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 1, 4'h3, 0, 4'h0, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 1, 4'h4, 0, 4'h0, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h0, 0, 4'h0, 0);

    // Physics only, back-to-back
    cyc(0, 8'h00, 1, 8'h25, 1, 0, 0, 4'h0, 0, 4'h0, 0);
    cyc(0, 8'h00, 1, 8'h26, 1, 1, 0, 4'h0, 0, 4'h0, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 1, 0, 4'h0, 0, 4'h0, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h0, 1, 4'h5, 0);
    chk("bram_addr_hold", bram_addr, 8'h26);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h0, 1, 4'h6, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h0, 0, 4'h0, 0);

    // Contention: physics held across 5 render cycles, accepted as render falls
    cyc(1, 8'h00, 1, 8'h30, 0, 0, 0, 4'h0, 0, 4'h0, 0);
    cyc(1, 8'h00, 1, 8'h30, 0, 1, 0, 4'h0, 0, 4'h0, 0);
    cyc(1, 8'h00, 1, 8'h30, 0, 1, 0, 4'h0, 0, 4'h0, 0);
    cyc(1, 8'h00, 1, 8'h30, 0, 1, 1, 4'h1, 0, 4'h0, 0);
    cyc(1, 8'h00, 1, 8'h30, 0, 1, 1, 4'h1, 0, 4'h0, 0);
    cyc(0, 8'h00, 1, 8'h30, 1, 1, 1, 4'h1, 0, 4'h0, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 1, 1, 4'h1, 0, 4'h0, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 1, 4'h1, 0, 4'h0, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h0, 1, 4'hB, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h0, 0, 4'h0, 0);

    // Interleave render/idle with physics always valid
    cyc(1, 8'h40, 1, 8'h50, 0, 0, 0, 4'h0, 0, 4'h0, 0);
    cyc(0, 8'h00, 1, 8'h50, 1, 1, 0, 4'h0, 0, 4'h0, 0);
    cyc(1, 8'h41, 1, 8'h51, 0, 1, 0, 4'h0, 0, 4'h0, 0);
    cyc(0, 8'h00, 1, 8'h51, 1, 1, 1, 4'h7, 0, 4'h0, 0);
    cyc(1, 8'h42, 1, 8'h52, 0, 1, 0, 4'h0, 1, 4'hC, 0);
    cyc(0, 8'h00, 1, 8'h52, 1, 1, 1, 4'h8, 0, 4'h0, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 1, 0, 4'h0, 1, 4'hD, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 1, 4'h9, 0, 4'h0, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h0, 1, 4'hE, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h0, 0, 4'h0, 0);

    // Starvation: flag visible after the 8th blocked cycle, sticky through the grant
    for (int i = 0; i < 12; i++)
      cyc(1, 8'h00, 1, 8'h60, 0, i >= 1, i >= 3, 4'h1, 0, 4'h0, i >= 8);
    cyc(0, 8'h00, 1, 8'h60, 1, 1, 1, 4'h1, 0, 4'h0, 1);
    cyc(0, 8'h00, 0, 8'h00, 1, 1, 1, 4'h1, 0, 4'h0, 1);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 1, 4'h1, 0, 4'h0, 1);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h0, 1, 4'h3, 1);
    starve_clr = 1'b1;
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h0, 0, 4'h0, 1);
    starve_clr = 1'b0;
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h0, 0, 4'h0, 0);

    // Clear coinciding with the 8th blocked cycle wins; count restarts from zero
    for (int j = 0; j < 17; j++) begin
      starve_clr = (j == 7);
      cyc(1, 8'h00, 1, 8'h60, 0, j >= 1, j >= 3, 4'h1, 0, 4'h0, j >= 16);
    end
    starve_clr = 1'b0;

    // Reset mid-flight: two physics reads issued, then asynchronous reset
    cyc(0, 8'h00, 1, 8'h25, 1, 1, 1, 4'h1, 0, 4'h0, 1);
    cyc(0, 8'h00, 1, 8'h26, 1, 1, 1, 4'h1, 0, 4'h0, 1);
    phys_req_addr = 8'h27;
    #1;
    chk("pre_rst_en", 8'(bram_en),          8'h1);
    chk("pre_rst_rv", 8'(render_rsp_valid), 8'h1);
    rst_in = 1'b1;
    #1;
    chk("mid_rst_en",    8'(bram_en),          8'h0);
    chk("mid_rst_addr",  bram_addr,            8'h00);
    chk("mid_rst_rv",    8'(render_rsp_valid), 8'h0);
    chk("mid_rst_pv",    8'(phys_rsp_valid),   8'h0);
    chk("mid_rst_ready", 8'(phys_req_ready),   8'h0);
    chk("mid_rst_sf",    8'(starve_flag),      8'h0);
    @(posedge clk_in); @(posedge clk_in); #1;
    chk("held_rst_ready", 8'(phys_req_ready), 8'h0);
    rst_in = 1'b0;
    for (int k = 0; k < 5; k++)
      cyc(0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h0, 0, 4'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
